uart_transmitter_fifo: RTL



---
 rtl/uart_transmitter_fifo_pkg.sv | 15 +
 rtl/uart_transmitter_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_transmitter_fifo.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_transmitter_fifo_pkg.sv
// Shared constants, engine state encoding and frame-length helper for the FIFO-buffered UART transmitter.
package uart_pkg;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_e;

   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
   endfunction
endpackage

// File: rtl/uart_transmitter_fifo_if.sv
// Producer-side valid/ready handshake into the UART transmitter FIFO.
interface uart_transmitter_fifo_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data_in;
   logic                 data_in_valid;
   logic                 data_in_ready;

   modport master (output data_in, output data_in_valid, input data_in_ready);
   modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a combinational head word, feeding the UART transmit engine.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int COUNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   output logic               empty
);
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [COUNT_W-1:0] count_q;
   logic               do_push;
   logic               do_pop;

   assign full    = (count_q == COUNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot being written, so a full FIFO may still take a word.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/uart_transmitter_fifo.sv
// Configurable-frame UART transmitter; a small input FIFO lets bursts leave back-to-back with no idle gap.
module uart_transmitter_fifo
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4,
   localparam int COUNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_transmitter_fifo_if.slave tx_if,
   output logic                   serial_out,
   output logic                   busy,
   output logic [COUNT_W-1:0]     fifo_count
);
   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
   localparam int CLK_W = $clog2(SYMBOL_EDGE_TIME);
   localparam int IDX_W = $clog2(FRAME_BITS);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_transmitter_fifo: DATA_BITS must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_transmitter_fifo: STOP_BITS must be 1 or 2");
   end
   if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
      $error("uart_transmitter_fifo: PARITY must be 0, 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_transmitter_fifo: FIFO_DEPTH must be a power of two >= 2");
   end
   if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
      $error("uart_transmitter_fifo: CLOCK_FREQ/BAUD_RATE must be >= 2");
   end

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_BITS-1:0]  fifo_dout;
   logic                  load;
   logic                  last_tick;
   logic                  parity_bit;
   logic [FRAME_BITS-1:0] frame_d;

   tx_state_e             state_q;
   logic [CLK_W-1:0]      clk_count_q;
   logic [IDX_W-1:0]      bit_idx_q;
   logic [FRAME_BITS-2:0] shift_q;
   logic                  serial_q;

   assign tx_if.data_in_ready = !fifo_full;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_if.data_in_valid && !fifo_full),
      .pop   (load),
      .din   (tx_if.data_in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A frame ends on the final cycle of its last stop bit; reloading there keeps frames contiguous.
   assign last_tick = (state_q == SEND) &&
                      (clk_count_q == CLK_W'(SYMBOL_EDGE_TIME - 1)) &&
                      (bit_idx_q == IDX_W'(FRAME_BITS - 1));
   assign load = !fifo_empty && ((state_q == IDLE) || last_tick);

   always_comb begin
      parity_bit = ^fifo_dout;
      if (PARITY == PARITY_ODD) begin
         parity_bit = ~parity_bit;
      end
      frame_d = '1;
      frame_d[0] = 1'b0;
      frame_d[DATA_BITS:1] = fifo_dout;
      if (PARITY != PARITY_NONE) begin
         frame_d[DATA_BITS+1] = parity_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         clk_count_q <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '1;
         serial_q    <= 1'b1;
      end else if (load) begin
         state_q     <= SEND;
         clk_count_q <= '0;
         bit_idx_q   <= '0;
         shift_q     <= frame_d[FRAME_BITS-1:1];
         serial_q    <= frame_d[0];
      end else if (state_q == SEND) begin
         if (clk_count_q == CLK_W'(SYMBOL_EDGE_TIME - 1)) begin
            clk_count_q <= '0;
            if (bit_idx_q == IDX_W'(FRAME_BITS - 1)) begin
               state_q  <= IDLE;
               serial_q <= 1'b1;
            end else begin
               bit_idx_q <= bit_idx_q + 1'b1;
               serial_q  <= shift_q[0];
               shift_q   <= {1'b1, shift_q[FRAME_BITS-2:1]};
            end
         end else begin
            clk_count_q <= clk_count_q + 1'b1;
         end
      end
   end

   assign serial_out = serial_q;
   assign busy       = (state_q == SEND) || !fifo_empty;
endmodule
